// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the sequential restoring divider.
package div_pkg;
  localparam int DIV_W     = 32;
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/seq_divider_if.sv
// Start/operand/result bundle between a requester and seq_divider.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int W = DIV_W
);
  logic         load;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         valid;
  logic         busy;
  logic         div0;

  modport master (output load, a, b, input quotient, remainder, valid, busy, div0);
  modport slave  (input load, a, b, output quotient, remainder, valid, busy, div0);
endinterface

// File: rtl/div_trial_sub.sv
// One-bit-wider trial subtractor: partial remainder minus divisor, plus the "fits" flag.
module div_trial_sub
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W:0]   s_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   difference_o,
  output logic         ge_o
);
  assign difference_o = s_i - {1'b0, divisor_i};
  assign ge_o         = (s_i >= {1'b0, divisor_i});
endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock, W iterations.
module seq_divider
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  div_state_e     state_q, state_d;
  logic [2*W-1:0] r_q, r_d;
  logic [W-1:0]   divisor_q, divisor_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           div0_q, div0_d;

  logic [W:0]     diff;
  logic           ge;

  // Upper W+1 bits of R are the shifted-in partial remainder under test.
  div_trial_sub #(.W(W)) u_trial (
    .s_i          (r_q[2*W-1:W-1]),
    .divisor_i    (divisor_q),
    .difference_o (diff),
    .ge_o         (ge)
  );

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    div0_d    = div0_q;
    if (bus.load) begin
      // A load restarts from any state, aborting an in-flight division.
      state_d   = BUSY;
      r_d       = {{W{1'b0}}, bus.a};
      divisor_d = bus.b;
      cnt_d     = '0;
      div0_d    = (bus.b == '0);
    end else begin
      unique case (state_q)
        BUSY: begin
          if (ge) r_d = {diff[W-1:0], r_q[W-2:0], 1'b1};
          else    r_d = {r_q[2*W-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      r_q       <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      div0_q    <= div0_d;
    end
  end

  assign bus.quotient  = r_q[W-1:0];
  assign bus.remainder = r_q[2*W-1:W];
  assign bus.valid     = (state_q == DONE);
  assign bus.busy      = (state_q == BUSY);
  assign bus.div0      = div0_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: known quotients, latency, restart, reset abort, 4x4 sweep.
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   chks = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.W(W)) bus ();

  seq_divider #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle load, scrambles the operands afterwards, and waits for valid.
  // lat counts edges from the load edge (inclusive) to the edge where valid rises.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic d0, output int lat);
    bus.load = 1'b1;
    bus.a    = a;
    bus.b    = b;
    tick();
    bus.load = 1'b0;
    bus.a    = ~a;
    bus.b    = b ^ 32'h5A5A_0001;
    lat = 1;
    while (!bus.valid && lat < 100) begin
      tick();
      lat++;
    end
    q  = bus.quotient;
    r  = bus.remainder;
    d0 = bus.div0;
  endtask

  logic [W-1:0] q, r;
  logic         d0;
  int           lat;
  int           rises;
  logic         pv;

  initial begin
    reset    = 1'b1;
    bus.load = 1'b0;
    bus.a    = '0;
    bus.b    = '0;
    tick();
    tick();
    chk("rst_valid", 64'(bus.valid), 64'd0);
    chk("rst_busy",  64'(bus.busy),  64'd0);
    chk("rst_q",     64'(bus.quotient),  64'd0);
    chk("rst_r",     64'(bus.remainder), 64'd0);
    reset = 1'b0;
    tick();

    // 100 / 7 with latency check
    run_div(32'd100, 32'd7, q, r, d0, lat);
    chk("lat_100_7", 64'(lat), 64'd33);
    chk("q_100_7",   64'(q),   64'd14);
    chk("r_100_7",   64'(r),   64'd2);
    chk("d0_100_7",  64'(d0),  64'd0);
    repeat (5) tick();
    chk("hold_valid", 64'(bus.valid),    64'd1);
    chk("hold_q",     64'(bus.quotient), 64'd14);
    chk("hold_r",     64'(bus.remainder), 64'd2);

    // load during DONE drops valid next cycle
    bus.load = 1'b1;
    bus.a    = 32'hFFFF_FFFF;
    bus.b    = 32'd1;
    tick();
    bus.load = 1'b0;
    chk("done_reload_valid", 64'(bus.valid), 64'd0);
    chk("done_reload_busy",  64'(bus.busy),  64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    run_div(32'hFFFF_FFFF, 32'd1, q, r, d0, lat);
    chk("q_max_1", 64'(q), 64'hFFFF_FFFF);
    chk("r_max_1", 64'(r), 64'd0);

    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, q, r, d0, lat);
    chk("q_max_max", 64'(q), 64'd1);
    chk("r_max_max", 64'(r), 64'd0);

    run_div(32'd5, 32'd9, q, r, d0, lat);
    chk("q_5_9", 64'(q), 64'd0);
    chk("r_5_9", 64'(r), 64'd5);

    run_div(32'h1234_5678, 32'd0, q, r, d0, lat);
    chk("q_div0",  64'(q),  64'hFFFF_FFFF);
    chk("r_div0",  64'(r),  64'h1234_5678);
    chk("d0_div0", 64'(d0), 64'd1);

    // restart mid-flight: only the second operation may raise valid
    bus.load = 1'b1;
    bus.a    = 32'd1000;
    bus.b    = 32'd3;
    tick();
    bus.load = 1'b0;
    rises = 0;
    pv    = bus.valid;
    repeat (10) begin
      tick();
      if (bus.valid && !pv) rises++;
      pv = bus.valid;
    end
    chk("restart_d0_clear", 64'(bus.div0), 64'd0);
    bus.load = 1'b1;
    bus.a    = 32'h8000_0000;
    bus.b    = 32'd16;
    tick();
    bus.load = 1'b0;
    pv = bus.valid;
    repeat (60) begin
      tick();
      if (bus.valid && !pv) rises++;
      pv = bus.valid;
    end
    chk("restart_rises", 64'(rises), 64'd1);
    chk("restart_q", 64'(bus.quotient),  64'h0800_0000);
    chk("restart_r", 64'(bus.remainder), 64'd0);

    // reset at BUSY cycle 20 abandons the operation
    bus.load = 1'b1;
    bus.a    = 32'd12345;
    bus.b    = 32'd77;
    tick();
    bus.load = 1'b0;
    repeat (19) tick();
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    bus.load = 1'b1;
    tick();
    reset = 1'b0;
    bus.load = 1'b0;
    chk("abort_valid", 64'(bus.valid),     64'd0);
    chk("abort_busy",  64'(bus.busy),      64'd0);
    chk("abort_q",     64'(bus.quotient),  64'd0);
    chk("abort_r",     64'(bus.remainder), 64'd0);
    chk("abort_d0",    64'(bus.div0),      64'd0);
    rises = 0;
    repeat (40) begin
      tick();
      if (bus.valid) rises++;
    end
    chk("abort_no_valid", 64'(rises), 64'd0);

    // exhaustive 4-bit by 4-bit sweep
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 1; bi < 16; bi++) begin
        run_div(32'(ai), 32'(bi), q, r, d0, lat);
        chk($sformatf("sweep_q_%0d_%0d", ai, bi), 64'(q), 64'(ai / bi));
        chk($sformatf("sweep_r_%0d_%0d", ai, bi), 64'(r), 64'(ai % bi));
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter W, default 32: operand width in bits; all widths below are given for W=32.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port load, input, 1: synchronous start strobe; samples a and b.
REQ-005 SHALL have port a, input, 32: unsigned dividend.
REQ-006 SHALL have port b, input, 32: unsigned divisor.
REQ-007 SHALL have port quotient, output, 32: unsigned quotient.
REQ-008 SHALL have port remainder, output, 32: unsigned remainder.
REQ-009 SHALL have port valid, output, 1: high when quotient, remainder and div0 hold a finished result.
REQ-010 SHALL have port busy, output, 1: high while iterations are in progress.
REQ-011 SHALL have port div0, output, 1: high with valid when the latched divisor was zero.

Function
REQ-012 SHALL implement a restoring shift-subtract divider with a 32-bit divisor register, a 64-bit combined remainder/quotient register R, and a 33-bit trial subtractor.
REQ-013 SHALL use state machine states IDLE, BUSY and DONE.
REQ-014 SHALL, on an edge where load=1 and reset=0, from any state: latch divisor<=b, set R<={32'h0,a}, clear the iteration counter, set div0<=(b==0), enter BUSY, and drive valid=0 from the next cycle.
REQ-015 SHALL, on each BUSY edge: form S=R[63:31] (33 bits) and compute D=S-{1'b0,divisor}; if S>=divisor, R<={D[31:0],R[30:0],1'b1}, else R<={R[62:0],1'b0}; then increment the counter.
REQ-016 SHALL move to DONE after exactly 32 BUSY edges, so that valid rises 33 edges after the load edge.
REQ-017 SHALL drive quotient=R[31:0] and remainder=R[63:32] continuously; these values are meaningful only while valid=1.
REQ-018 SHALL keep valid=1 and R stable in DONE until the next load or reset.
REQ-019 SHALL define valid=(state==DONE) and busy=(state==BUSY).
REQ-020 SHALL, when load=1 arrives during BUSY, abort the current division and restart it with the new operands; no valid pulse is produced for the aborted operation.
REQ-021 SHALL, when load=1 arrives during DONE, drop valid on the following cycle, so that each result produces a fresh rising edge of valid.
REQ-022 SHALL handle divisor 0 with no special datapath: the algorithm itself yields quotient=32'hFFFFFFFF and remainder=a, and div0=1.
REQ-023 SHALL ignore changes on a and b except on load edges.

Reset
REQ-024 SHALL, on an edge where reset=1, enter IDLE, clear R, the divisor register, the counter and div0, and hold valid=0 and busy=0.
REQ-025 SHALL give reset priority over a simultaneous load.
REQ-026 SHALL, on reset during BUSY, abandon the operation with no valid pulse.

Structure
REQ-027 SHALL take from a shared package div_pkg: the default width constant (32), the iteration count (32), and the state enum typedef (IDLE, BUSY, DONE).
REQ-028 SHALL place the 33-bit trial subtractor in one combinational sub-module, div_trial_sub, with outputs difference and ge (S>=divisor).

Verification
REQ-029 SHALL verify a=100, b=7, load for 1 cycle -> valid rises 33 edges after the load edge with quotient=14, remainder=2, div0=0.
REQ-030 SHALL verify a=32'hFFFFFFFF, b=1 -> quotient=32'hFFFFFFFF, remainder=0; and a=32'hFFFFFFFF, b=32'hFFFFFFFF -> quotient=1, remainder=0.
REQ-031 SHALL verify a=5, b=9 -> quotient=0, remainder=5.
REQ-032 SHALL verify a=32'h12345678, b=0 -> quotient=32'hFFFFFFFF, remainder=32'h12345678, div0=1.
REQ-033 SHALL verify restart: start 1000/3, then 10 cycles later load a=32'h80000000, b=16 -> exactly one valid rise, quotient=32'h08000000, remainder=0.
REQ-034 SHALL verify reset=1 at BUSY cycle 20 -> next cycle valid=0, busy=0, quotient=0, remainder=0; then an exhaustive 4-bit by 4-bit sweep (b!=0) matches a/b and a%b.
